// File: rtl/axi_burst_mem_slave_pkg.sv
// Shared types and helpers for the AXI burst memory slave.
package axi_burst_mem_slave_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Reserved burst type, or WRAP with a length that is not 2/4/8/16 beats.
  // Such bursts walk the address like INCR and flag every beat as SLVERR.
  function automatic logic burst_illegal(input logic [1:0] burst, input logic [7:0] len);
    if (burst == 2'd3) return 1'b1;
    if (burst == BURST_WRAP)
      return !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
    return 1'b0;
  endfunction

endpackage

// File: rtl/axi_burst_mem_slave_addr_gen.sv
// Next-beat word address for one AXI channel.
module axi_burst_addr_gen
  import axi_burst_mem_slave_pkg::*;
#(
  parameter int WORD_AW = 10
) (
  input  logic [WORD_AW-1:0] cur_word,
  input  logic [7:0]         len,
  input  logic [1:0]         burst,
  output logic [WORD_AW-1:0] next_word,
  output logic               wrap_err
);

  logic [WORD_AW-1:0] wrap_mask;
  logic [WORD_AW-1:0] cur_inc;

  // WRAP keeps the bits above the (power-of-two) block size and increments
  // only the bits inside it; illegal bursts fall through to INCR.
  always_comb begin
    wrap_err  = burst_illegal(burst, len);
    wrap_mask = WORD_AW'(len);
    cur_inc   = cur_word + WORD_AW'(1);
    next_word = cur_inc;
    if (burst == BURST_FIXED)
      next_word = cur_word;
    else if ((burst == BURST_WRAP) && !wrap_err)
      next_word = (cur_word & ~wrap_mask) | (cur_inc & wrap_mask);
  end

endmodule

// File: rtl/axi_burst_mem_slave.sv
// AXI4 slave terminating bursts in a local word-addressed memory.
//
// state  | meaning
// W_IDLE | awready high, waiting for a write address
// W_DATA | wready high, consuming len+1 write beats
// W_RESP | bvalid high until bready
// R_IDLE | arready high, waiting for a read address
// R_DATA | rvalid high, one beat per accepted rready
module axi_burst_mem_slave
  import axi_burst_mem_slave_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                    s00_axi_aclk,
  input  logic                    s00_axi_aresetn,
  input  logic [ID_WIDTH-1:0]     s00_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [7:0]              s00_axi_awlen,
  input  logic [1:0]              s00_axi_awburst,
  input  logic                    s00_axi_awvalid,
  output logic                    s00_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                    s00_axi_wlast,
  input  logic                    s00_axi_wvalid,
  output logic                    s00_axi_wready,
  output logic [ID_WIDTH-1:0]     s00_axi_bid,
  output logic [1:0]              s00_axi_bresp,
  output logic                    s00_axi_bvalid,
  input  logic                    s00_axi_bready,
  input  logic [ID_WIDTH-1:0]     s00_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [7:0]              s00_axi_arlen,
  input  logic [1:0]              s00_axi_arburst,
  input  logic                    s00_axi_arvalid,
  output logic                    s00_axi_arready,
  output logic [ID_WIDTH-1:0]     s00_axi_rid,
  output logic [DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]              s00_axi_rresp,
  output logic                    s00_axi_rlast,
  output logic                    s00_axi_rvalid,
  input  logic                    s00_axi_rready
);

  localparam int BYTES   = DATA_WIDTH / 8;
  localparam int OFF     = $clog2(BYTES);
  localparam int WORD_AW = ADDR_WIDTH - OFF;
  localparam int MW      = $clog2(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  function automatic logic in_range(input logic [WORD_AW-1:0] word);
    return {1'b0, word} < (WORD_AW + 1)'(MEM_DEPTH);
  endfunction

  // Byte-offset bits never take part in addressing.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s00_axi_awaddr[OFF-1:0], s00_axi_araddr[OFF-1:0]};

  // ---------------- write channel ----------------
  wr_state_t             w_state;
  logic [ID_WIDTH-1:0]   w_id;
  logic [WORD_AW-1:0]    w_word, w_next;
  logic [7:0]            w_len, w_cnt;
  logic [1:0]            w_burst;
  logic                  w_err, w_wrap_err;
  logic                  w_fire, w_in_range, w_beat_err;

  axi_burst_addr_gen #(.WORD_AW(WORD_AW)) u_w_addr (
    .cur_word  (w_word),
    .len       (w_len),
    .burst     (w_burst),
    .next_word (w_next),
    .wrap_err  (w_wrap_err)
  );

  assign w_fire     = s00_axi_wvalid & s00_axi_wready;
  assign w_in_range = in_range(w_word);
  assign w_beat_err = !w_in_range | w_wrap_err;

  // Byte-masked store of an accepted in-range write beat; contents survive reset.
  always_ff @(posedge s00_axi_aclk) begin
    if (w_fire && w_in_range) begin
      for (int b = 0; b < BYTES; b++) begin
        if (s00_axi_wstrb[b])
          mem[w_word[MW-1:0]][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
      end
    end
  end

  // Write FSM: address capture, len+1 beats regardless of wlast, then response.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      w_state         <= W_IDLE;
      s00_axi_awready <= 1'b0;
      s00_axi_wready  <= 1'b0;
      s00_axi_bvalid  <= 1'b0;
      s00_axi_bid     <= '0;
      s00_axi_bresp   <= RESP_OKAY;
      w_id            <= '0;
      w_word          <= '0;
      w_len           <= '0;
      w_cnt           <= '0;
      w_burst         <= '0;
      w_err           <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          s00_axi_awready <= 1'b1;
          if (s00_axi_awvalid && s00_axi_awready) begin
            w_id            <= s00_axi_awid;
            w_word          <= s00_axi_awaddr[ADDR_WIDTH-1:OFF];
            w_len           <= s00_axi_awlen;
            w_burst         <= s00_axi_awburst;
            w_cnt           <= '0;
            w_err           <= 1'b0;
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b1;
            w_state         <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            if (w_cnt == w_len) begin
              s00_axi_wready <= 1'b0;
              s00_axi_bvalid <= 1'b1;
              s00_axi_bid    <= w_id;
              s00_axi_bresp  <= (w_err || w_beat_err || !s00_axi_wlast) ? RESP_SLVERR : RESP_OKAY;
              w_state        <= W_RESP;
            end else begin
              w_err  <= w_err | w_beat_err | s00_axi_wlast;
              w_cnt  <= w_cnt + 8'd1;
              w_word <= w_next;
            end
          end
        end
        W_RESP: begin
          if (s00_axi_bready) begin
            s00_axi_bvalid  <= 1'b0;
            s00_axi_awready <= 1'b1;
            w_state         <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // ---------------- read channel ----------------
  rd_state_t             r_state;
  logic [WORD_AW-1:0]    r_word, r_next, ar_word;
  logic [7:0]            r_len, r_cnt;
  logic [1:0]            r_burst;
  logic                  r_wrap_err;

  axi_burst_addr_gen #(.WORD_AW(WORD_AW)) u_r_addr (
    .cur_word  (r_word),
    .len       (r_len),
    .burst     (r_burst),
    .next_word (r_next),
    .wrap_err  (r_wrap_err)
  );

  assign ar_word = s00_axi_araddr[ADDR_WIDTH-1:OFF];

  // Read FSM: first word loads on the AR edge, each accepted beat loads the next.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      r_state         <= R_IDLE;
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid  <= 1'b0;
      s00_axi_rlast   <= 1'b0;
      s00_axi_rid     <= '0;
      s00_axi_rdata   <= '0;
      s00_axi_rresp   <= RESP_OKAY;
      r_word          <= '0;
      r_len           <= '0;
      r_cnt           <= '0;
      r_burst         <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          s00_axi_arready <= 1'b1;
          if (s00_axi_arvalid && s00_axi_arready) begin
            r_word          <= ar_word;
            r_len           <= s00_axi_arlen;
            r_burst         <= s00_axi_arburst;
            r_cnt           <= '0;
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b1;
            s00_axi_rid     <= s00_axi_arid;
            s00_axi_rdata   <= in_range(ar_word) ? mem[ar_word[MW-1:0]] : '0;
            s00_axi_rresp   <= (burst_illegal(s00_axi_arburst, s00_axi_arlen) || !in_range(ar_word))
                               ? RESP_SLVERR : RESP_OKAY;
            s00_axi_rlast   <= (s00_axi_arlen == 8'd0);
            r_state         <= R_DATA;
          end
        end
        R_DATA: begin
          if (s00_axi_rready) begin
            if (s00_axi_rlast) begin
              s00_axi_rvalid  <= 1'b0;
              s00_axi_rlast   <= 1'b0;
              s00_axi_arready <= 1'b1;
              r_state         <= R_IDLE;
            end else begin
              r_cnt         <= r_cnt + 8'd1;
              r_word        <= r_next;
              s00_axi_rdata <= in_range(r_next) ? mem[r_next[MW-1:0]] : '0;
              s00_axi_rresp <= (r_wrap_err || !in_range(r_next)) ? RESP_SLVERR : RESP_OKAY;
              s00_axi_rlast <= ((r_cnt + 8'd1) == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Randomized self-checking bench with a word-array reference model.
module tb_axi_burst_mem_slave;

  localparam int DW = 512;
  localparam int NB = DW / 8;
  localparam int DEPTH = 256;
  localparam int WORDS = 1024;

  logic           clk = 1'b0;
  logic           aresetn;
  logic [3:0]     awid, bid, arid, rid;
  logic [15:0]    awaddr, araddr;
  logic [7:0]     awlen, arlen;
  logic [1:0]     awburst, arburst, bresp, rresp;
  logic           awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic           arvalid, arready, rlast, rvalid, rready;
  logic [DW-1:0]  wdata, rdata;
  logic [NB-1:0]  wstrb;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  axi_burst_mem_slave dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(aresetn),
    .s00_axi_awid(awid), .s00_axi_awaddr(awaddr), .s00_axi_awlen(awlen),
    .s00_axi_awburst(awburst), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wlast(wlast),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bid(bid), .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_arid(arid), .s00_axi_araddr(araddr), .s00_axi_arlen(arlen),
    .s00_axi_arburst(arburst), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rid(rid), .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rlast(rlast),
    .s00_axi_rvalid(rvalid), .s00_axi_rready(rready)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w;
    for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic bit bad_burst(input int len, input int burst);
    return (burst == 3) || (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  // Word touched by beat i of a burst, straight from the burst rules.
  function automatic int beat_word(input int start, input int len, input int burst, input int i);
    int sz, base;
    if (burst == 0) return start;
    if (burst == 2 && !bad_burst(len, burst)) begin
      sz   = len + 1;
      base = start - (start % sz);
      return base + ((start - base + i) % sz);
    end
    return (start + i) % WORDS;
  endfunction

  task automatic axi_write(input logic [3:0] id, input int start, input int len, input int burst,
                           input logic [NB-1:0] strb, input bit use_fixed,
                           input logic [DW-1:0] fixed_data, input int bad_last, input int b_delay);
    int t, w;
    bit exp_err;
    logic [DW-1:0] d;
    exp_err = bad_burst(len, burst);
    @(negedge clk);
    awid = id; awaddr = 16'(start * 64 + $urandom_range(0, 63));
    awlen = 8'(len); awburst = 2'(burst); awvalid = 1'b1;
    t = 0;
    while (!awready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) chk("aw_timeout", awready, 1);
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      d = use_fixed ? fixed_data : rnd_word();
      wdata = d; wstrb = strb; wvalid = 1'b1;
      wlast = (bad_last >= 0) ? (i == bad_last) : (i == len);
      t = 0;
      while (!wready && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) chk("w_timeout", wready, 1);
      w = beat_word(start, len, burst, i);
      if (w < DEPTH) begin
        for (int b = 0; b < NB; b++) if (strb[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
      end else exp_err = 1'b1;
      @(negedge clk);
    end
    if (bad_last >= 0) exp_err = 1'b1;
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;
    t = 0;
    while (!bvalid && t < 200) begin @(negedge clk); t++; end
    chk("bvalid", bvalid, 1);
    for (int k = 0; k < b_delay; k++) begin
      chk("b_hold", bvalid, 1);
      chk("aw_blocked", awready, 0);
      @(negedge clk);
    end
    chk("bid", bid, id);
    chk("bresp", bresp, exp_err ? 2 : 0);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("b_done", bvalid, 0);
  endtask

  task automatic axi_read(input logic [3:0] id, input int start, input int len, input int burst,
                          input int stall_mode);
    int t, w;
    bit stall;
    logic [DW-1:0] exp_d;
    logic [1:0] exp_r;
    @(negedge clk);
    arid = id; araddr = 16'(start * 64 + $urandom_range(0, 63));
    arlen = 8'(len); arburst = 2'(burst); arvalid = 1'b1;
    t = 0;
    while (!arready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) chk("ar_timeout", arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      w = beat_word(start, len, burst, i);
      exp_d = (w < DEPTH) ? ref_mem[w] : '0;
      exp_r = (bad_burst(len, burst) || w >= DEPTH) ? 2'b10 : 2'b00;
      t = 0;
      while (!rvalid && t < 200) begin @(negedge clk); t++; end
      chk("rvalid", rvalid, 1);
      stall = (stall_mode == 1) ? (i % 2 == 1) : (stall_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (stall) begin
        rready = 1'b0;
        repeat (2) @(negedge clk);
        chk("r_stall_valid", rvalid, 1);
        chk("r_stall_data", rdata, exp_d);
      end
      rready = 1'b1;
      chk("rdata", rdata, exp_d);
      chk("rresp", rresp, exp_r);
      chk("rlast", rlast, (i == len) ? 1 : 0);
      chk("rid", rid, id);
      @(negedge clk);
      rready = 1'b0;
    end
    chk("r_done", rvalid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, ln, bt;
    logic [NB-1:0] ones;
    ones = '1;
    awid = '0; awaddr = '0; awlen = '0; awburst = '0; wdata = '0; wstrb = '0; wlast = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arburst = '0;
    aresetn = 1'b0;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_awready", awready, 0);
      chk("rst_arready", arready, 0);
      chk("rst_wready", wready, 0);
      chk("rst_bvalid", bvalid, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rlast", rlast, 0);
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    aresetn = 1'b1;
    @(negedge clk);
    chk("rel_awready", awready, 1);
    chk("rel_arready", arready, 1);

    axi_write(4'd0, 0, 255, 1, ones, 1'b0, '0, -1, 0);

    axi_write(4'd5, 1, 3, 1, ones, 1'b0, '0, -1, 0);
    axi_read(4'd5, 1, 3, 1, 0);

    axi_write(4'd1, 0, 0, 1, ones, 1'b1, '1, -1, 0);
    axi_write(4'd1, 0, 0, 1, NB'(1), 1'b1, '0, -1, 0);
    axi_read(4'd2, 0, 0, 1, 0);

    axi_write(4'd2, 6, 3, 2, ones, 1'b0, '0, -1, 0);
    axi_read(4'd3, 4, 3, 1, 0);
    axi_write(4'd3, 20, 2, 2, ones, 1'b0, '0, -1, 0);
    axi_read(4'd3, 20, 2, 2, 0);

    axi_write(4'd9, DEPTH - 1, 1, 1, ones, 1'b0, '0, -1, 0);
    axi_read(4'd9, DEPTH - 1, 1, 1, 0);
    axi_read(4'd10, WORDS - 2, 3, 1, 0);

    axi_read(4'd7, 10, 7, 1, 1);
    axi_write(4'd4, 30, 0, 1, ones, 1'b0, '0, -1, 5);

    axi_write(4'd6, 40, 3, 1, ones, 1'b0, '0, 1, 0);
    axi_read(4'd6, 40, 3, 1, 0);
    axi_write(4'd11, 50, 2, 3, ones, 1'b0, '0, -1, 0);
    axi_read(4'd11, 50, 2, 3, 0);
    axi_write(4'd12, 60, 3, 0, {$urandom, $urandom}, 1'b0, '0, -1, 0);
    axi_read(4'd12, 60, 2, 0, 0);

    for (int n = 0; n < 25; n++) begin
      bt = $urandom_range(0, 3);
      if (bt == 2 && $urandom_range(0, 3) != 0) ln = (2 << $urandom_range(0, 3)) - 1;
      else ln = $urandom_range(0, 20);
      st = $urandom_range(0, 280);
      axi_write(4'($urandom), st, ln, bt, {$urandom, $urandom}, 1'b0, '0, -1, $urandom_range(0, 2));
      axi_read(4'($urandom), st, ln, bt, 2);
    end

    fork
      axi_write(4'd13, 100, 7, 1, ones, 1'b0, '0, -1, 0);
      axi_read(4'd14, 200, 7, 1, 2);
    join

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
